// File: rtl/rv32i_cpu.sv
// Multi-cycle RV32I integer core: FETCH -> EXEC -> (MEM) -> FETCH, with separate
// instruction-fetch and load/store ports using address/strobe/ready handshakes.
module rv32i_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_data,
  input  logic [31:0] mem_data,
  input  logic        instr_ready,
  input  logic        mem_ready,
  output logic [31:0] instr_addr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_wflag,
  output logic        mem_we,
  output logic        mem_re
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [2:0]  mem_wflag_q, mem_wflag_d;
  logic        mem_we_q, mem_we_d, mem_re_q, mem_re_d;

  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [31:0] rf_wdata;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4, alu_b, alu_y, load_val;
  logic signed [31:0] sra_y;
  logic        alu_alt, br_take;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'd0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;

  // Bit 30 selects SUB/SRA for register ops, but only SRAI among immediate ops.
  assign alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;
  assign alu_alt = ir_q[30] && ((opcode == OP_REG) || (funct3 == 3'b101));
  assign shamt   = alu_b[4:0];
  assign sra_y   = $signed(rs1_val) >>> shamt;

  always_comb begin
    case (funct3)
      3'b000:  alu_y = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
      3'b001:  alu_y = rs1_val << shamt;
      3'b010:  alu_y = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_y = {31'd0, rs1_val < alu_b};
      3'b100:  alu_y = rs1_val ^ alu_b;
      3'b101:  alu_y = alu_alt ? sra_y : (rs1_val >> shamt);
      3'b110:  alu_y = rs1_val | alu_b;
      default: alu_y = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  br_take = (rs1_val == rs2_val);
      3'b001:  br_take = (rs1_val != rs2_val);
      3'b100:  br_take = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_take = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_take = (rs1_val < rs2_val);
      3'b111:  br_take = (rs1_val >= rs2_val);
      default: br_take = 1'b0;
    endcase
  end

  // The registered access size doubles as the load-extension selector in MEM.
  always_comb begin
    case (mem_wflag_q)
      3'b000:  load_val = {{24{mem_data[7]}}, mem_data[7:0]};
      3'b001:  load_val = {{16{mem_data[15]}}, mem_data[15:0]};
      3'b100:  load_val = {24'd0, mem_data[7:0]};
      3'b101:  load_val = {16'd0, mem_data[15:0]};
      default: load_val = mem_data;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wflag_d = mem_wflag_q;
    mem_we_d    = mem_we_q;
    mem_re_d    = mem_re_q;
    rf_we       = 1'b0;
    rf_wdata    = alu_y;
    case (state_q)
      S_FETCH: begin
        if (instr_ready) begin
          ir_d    = instr_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_plus4;
        case (opcode)
          OP_LUI:   begin rf_we = 1'b1; rf_wdata = imm_u; end
          OP_AUIPC: begin rf_we = 1'b1; rf_wdata = pc_q + imm_u; end
          OP_JAL: begin
            rf_we = 1'b1; rf_wdata = pc_plus4; pc_d = pc_q + imm_j;
          end
          OP_JALR: begin
            rf_we = 1'b1; rf_wdata = pc_plus4; pc_d = (rs1_val + imm_i) & ~32'd1;
          end
          OP_BRANCH: if (br_take) pc_d = pc_q + imm_b;
          OP_IMM, OP_REG: rf_we = 1'b1;
          OP_LOAD: begin
            mem_addr_d = rs1_val + imm_i; mem_wflag_d = funct3;
            mem_re_d = 1'b1; pc_d = pc_q; state_d = S_MEM;
          end
          OP_STORE: begin
            mem_addr_d = rs1_val + imm_s; mem_wflag_d = funct3; mem_wdata_d = rs2_val;
            mem_we_d = 1'b1; pc_d = pc_q; state_d = S_MEM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          rf_we    = mem_re_q;
          rf_wdata = load_val;
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          pc_d     = pc_plus4;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wflag_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wflag_q <= mem_wflag_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

  // A reset edge must never commit a pending register write.
  always_ff @(posedge clk) begin
    if (!rst_n && rf_we && (rd != 5'd0)) rf_q[rd] <= rf_wdata;
  end

  assign instr_addr = pc_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wflag  = mem_wflag_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
endmodule

// File: tb/tb_rv32i_cpu.sv
// Directed bench for rv32i_cpu: instructions are placed at the expected PC just
// before each fetch; register contents are observed by storing them to memory.
module tb_rv32i_cpu;
  logic        clk = 1'b0;
  logic        rst_n, instr_ready, mem_ready;
  logic [31:0] instr_data, mem_data, instr_addr, mem_addr, mem_wdata;
  logic [2:0]  mem_wflag;
  logic        mem_we, mem_re;

  logic [31:0] imem [256];
  logic [31:0] exp_pc;
  int checks = 0;
  int failures = 0;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;

  always #5 clk = ~clk;
  assign instr_data = imem[instr_addr[9:2]];

  rv32i_cpu #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .instr_data(instr_data), .mem_data(mem_data),
    .instr_ready(instr_ready), .mem_ready(mem_ready), .instr_addr(instr_addr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wflag(mem_wflag),
    .mem_we(mem_we), .mem_re(mem_re)
  );

  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [11:0] imm,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(rd, rs1, 3'b000, imm, OP_IMM);
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [6:0] f7);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [19:0] imm,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Non-memory instruction: PC holds through EXEC, then moves to next_pc.
  task automatic run(input string tag, input logic [31:0] ins, input logic [31:0] next_pc);
    imem[exp_pc[9:2]] = ins;
    tick();
    chk({tag, ":exec_pc"}, instr_addr, exp_pc);
    tick();
    chk({tag, ":pc"}, instr_addr, next_pc);
    chk({tag, ":strb"}, {30'd0, mem_we, mem_re}, 32'd0);
    $display("instr %-10s pc=%h ins=%h next=%h", tag, exp_pc, ins, instr_addr);
    exp_pc = next_pc;
  endtask

  task automatic seq(input string tag, input logic [31:0] ins);
    run(tag, ins, exp_pc + 32'd4);
  endtask

  task automatic mem_op(input string tag, input logic [31:0] ins, input logic is_st,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] flag, input logic [31:0] rdata, input int waits);
    imem[exp_pc[9:2]] = ins;
    mem_ready = 1'b0;
    mem_data  = rdata;
    tick();
    tick();
    chk({tag, ":addr"}, mem_addr, addr);
    if (is_st) chk({tag, ":wdata"}, mem_wdata, wdata);
    chk({tag, ":flag"}, {29'd0, mem_wflag}, {29'd0, flag});
    chk({tag, ":strb"}, {30'd0, mem_we, mem_re}, is_st ? 32'd2 : 32'd1);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk({tag, ":hold_addr"}, mem_addr, addr);
      chk({tag, ":hold_strb"}, {30'd0, mem_we, mem_re}, is_st ? 32'd2 : 32'd1);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk({tag, ":done_strb"}, {30'd0, mem_we, mem_re}, 32'd0);
    chk({tag, ":next_pc"}, instr_addr, exp_pc + 32'd4);
    $display("mem   %-10s pc=%h addr=%h wdata=%h rdata=%h waits=%0d",
             tag, exp_pc, mem_addr, mem_wdata, rdata, waits);
    exp_pc = exp_pc + 32'd4;
  endtask

  // Observe register r by storing it to address 0.
  task automatic show(input string tag, input logic [4:0] r, input logic [31:0] exp);
    mem_op(tag, enc_s(5'd0, r, 3'b010, 12'd0), 1'b1, 32'd0, exp, 3'b010, 32'd0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; instr_ready = 1'b1; mem_ready = 1'b0; mem_data = 32'd0; exp_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    chk("rst:pc", instr_addr, 32'h0);
    chk("rst:maddr", mem_addr, 32'h0);
    chk("rst:wdata", mem_wdata, 32'h0);
    chk("rst:flag", {29'd0, mem_wflag}, 32'd0);
    chk("rst:strb", {30'd0, mem_we, mem_re}, 32'd0);

    seq("addi_5", addi(5'd1, 5'd0, 12'd5));
    seq("addi_m7", addi(5'd2, 5'd1, 12'hFF9));
    show("x2", 5'd2, 32'hFFFF_FFFE);

    seq("lui", enc_u(5'd1, 20'h80000, OP_LUI));
    seq("addi_1", addi(5'd2, 5'd0, 12'd1));
    seq("addi_4", addi(5'd7, 5'd0, 12'd4));
    seq("sub", enc_r(5'd3, 5'd1, 5'd2, 3'b000, 7'h20));
    seq("slt", enc_r(5'd4, 5'd1, 5'd2, 3'b010, 7'h00));
    seq("sltu", enc_r(5'd5, 5'd1, 5'd2, 3'b011, 7'h00));
    seq("sra", enc_r(5'd6, 5'd1, 5'd7, 3'b101, 7'h20));
    seq("add", enc_r(5'd8, 5'd1, 5'd1, 3'b000, 7'h00));
    seq("srl", enc_r(5'd9, 5'd1, 5'd7, 3'b101, 7'h00));
    seq("xori", enc_i(5'd22, 5'd1, 3'b100, 12'hFFF, OP_IMM));
    seq("slli", enc_i(5'd24, 5'd2, 3'b001, 12'd31, OP_IMM));
    show("sub_res", 5'd3, 32'h7FFF_FFFF);
    show("slt_res", 5'd4, 32'h0000_0001);
    show("sltu_res", 5'd5, 32'h0000_0000);
    show("sra_res", 5'd6, 32'hF800_0000);
    show("add_res", 5'd8, 32'h0000_0000);
    show("srl_res", 5'd9, 32'h0800_0000);
    show("xori_res", 5'd22, 32'h7FFF_FFFF);
    show("slli_res", 5'd24, 32'h8000_0000);

    seq("addi_100", addi(5'd1, 5'd0, 12'h100));
    seq("lui_dead", enc_u(5'd2, 20'hDEADC, OP_LUI));
    seq("addi_eef", addi(5'd2, 5'd2, 12'hEEF));
    mem_op("sw", enc_s(5'd1, 5'd2, 3'b010, 12'd8), 1'b1, 32'h108, 32'hDEAD_BEEF, 3'b010, 32'd0, 2);
    mem_op("sb_neg", enc_s(5'd1, 5'd2, 3'b000, 12'hFFF), 1'b1, 32'hFF, 32'hDEAD_BEEF, 3'b000, 32'd0, 0);
    mem_op("lb", enc_i(5'd10, 5'd1, 3'b000, 12'd0, OP_LOAD), 1'b0, 32'h100, 32'd0, 3'b000, 32'h0000_0080, 0);
    mem_op("lbu", enc_i(5'd11, 5'd1, 3'b100, 12'd0, OP_LOAD), 1'b0, 32'h100, 32'd0, 3'b100, 32'h5555_5580, 0);
    mem_op("lh", enc_i(5'd12, 5'd1, 3'b001, 12'd2, OP_LOAD), 1'b0, 32'h102, 32'd0, 3'b001, 32'h0000_8001, 0);
    mem_op("lhu", enc_i(5'd13, 5'd1, 3'b101, 12'd2, OP_LOAD), 1'b0, 32'h102, 32'd0, 3'b101, 32'hAAAA_8001, 0);
    mem_op("lw", enc_i(5'd14, 5'd1, 3'b010, 12'hFFC, OP_LOAD), 1'b0, 32'hFC, 32'd0, 3'b010, 32'h1234_5678, 1);
    show("lb_res", 5'd10, 32'hFFFF_FF80);
    show("lbu_res", 5'd11, 32'h0000_0080);
    show("lh_res", 5'd12, 32'hFFFF_8001);
    show("lhu_res", 5'd13, 32'h0000_8001);
    show("lw_res", 5'd14, 32'h1234_5678);

    seq("addi_x15", addi(5'd15, 5'd0, 12'd5));
    seq("addi_x16", addi(5'd16, 5'd0, 12'd5));
    seq("addi_x17", addi(5'd17, 5'd0, 12'd6));
    run("beq_t", enc_b(5'd15, 5'd16, 3'b000, 13'd16), exp_pc + 32'd16);
    run("beq_n", enc_b(5'd15, 5'd17, 3'b000, 13'd16), exp_pc + 32'd4);
    run("bne_back", enc_b(5'd15, 5'd17, 3'b001, 13'h1FF8), exp_pc - 32'd8);
    run("blt_t", enc_b(5'd2, 5'd15, 3'b100, 13'd12), exp_pc + 32'd12);
    run("bltu_n", enc_b(5'd2, 5'd15, 3'b110, 13'd12), exp_pc + 32'd4);
    run("bge_t", enc_b(5'd15, 5'd2, 3'b101, 13'd8), exp_pc + 32'd8);
    run("bgeu_n", enc_b(5'd15, 5'd2, 3'b111, 13'd8), exp_pc + 32'd4);

    seq("addi_1f", addi(5'd1, 5'd0, 12'h01F));
    run("jalr_x0", enc_i(5'd0, 5'd1, 3'b000, 12'd1, OP_JALR), 32'h20);
    run("jal", enc_j(5'd18, 21'h1FFFF8), 32'h18);
    seq("addi_40", addi(5'd1, 5'd0, 12'h040));
    run("jalr_x1", enc_i(5'd1, 5'd1, 3'b000, 12'd3, OP_JALR), 32'h42);
    show("jal_link", 5'd18, 32'h24);
    show("jalr_link", 5'd1, 32'h20);

    run("ecall", 32'h0000_0073, exp_pc + 32'd4);
    run("unknown", 32'hFFFF_FFFF, exp_pc + 32'd4);
    seq("auipc", enc_u(5'd21, 20'h00001, OP_AUI));
    show("auipc_res", 5'd21, 32'h0000_1052);

    instr_ready = 1'b0;
    imem[exp_pc[9:2]] = addi(5'd19, 5'd0, 12'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall:pc", instr_addr, exp_pc);
      chk("stall:strb", {30'd0, mem_we, mem_re}, 32'd0);
    end
    instr_ready = 1'b1;
    seq("stall_go", addi(5'd19, 5'd0, 12'd2));
    show("stall_res", 5'd19, 32'd2);

    seq("addi_x20", addi(5'd20, 5'd0, 12'd7));
    imem[exp_pc[9:2]] = enc_i(5'd20, 5'd0, 3'b010, 12'd0, OP_LOAD);
    tick();
    tick();
    chk("rstmem:re", {30'd0, mem_we, mem_re}, 32'd1);
    rst_n = 1'b1; mem_ready = 1'b1; mem_data = 32'h0000_0BAD;
    tick();
    chk("rstmem:strb", {30'd0, mem_we, mem_re}, 32'd0);
    chk("rstmem:pc", instr_addr, 32'h0);
    chk("rstmem:maddr", mem_addr, 32'h0);
    rst_n = 1'b0; mem_ready = 1'b0; exp_pc = 32'd0;
    $display("reset during load, pc=%h", instr_addr);
    show("rstmem_x20", 5'd20, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
